// File: rtl/clock_pkg.sv
// Shared definitions for the clock-enable generator.
//   turbo_t        : CPU speed select encodings (3.5 / 7 / 14 / 28 MHz)
//   PH_*           : counter phases at which each fixed-rate strobe fires
//   CNT_LAST       : terminal value of the 4-bit 56 MHz phase counter
//   ce_cpu_hit()   : CPU enable decode for a given speed and counter value
package clock_pkg;

    typedef enum logic [1:0] {
        TURBO_3M5 = 2'b00,
        TURBO_7M  = 2'b01,
        TURBO_14M = 2'b10,
        TURBO_28M = 2'b11
    } turbo_t;

    localparam logic [3:0] PH_PE7M  = 4'd3;
    localparam logic [3:0] PH_NE7M  = 4'd7;
    localparam logic [3:0] PH_PE3M5 = 4'd7;
    localparam logic [3:0] PH_NE3M5 = 4'd15;
    localparam logic [3:0] CNT_LAST = 4'd15;

    // Every mode fires on the last phase of its sub-period, so all modes
    // share the pulse at CNT_LAST and none fires at count 0.
    function automatic logic ce_cpu_hit(input turbo_t mode, input logic [3:0] cnt);
        case (mode)
            TURBO_3M5: return cnt == PH_NE3M5;
            TURBO_7M:  return cnt[2:0] == PH_NE7M[2:0];
            TURBO_14M: return cnt[1:0] == PH_PE7M[1:0];
            default:   return cnt[0];
        endcase
    endfunction

endpackage

// File: rtl/clock_enable_if.sv
// Bundle of strobes and the stretched system reset leaving clock_enable.
//   pe7M / ne7M   : 7 MHz positive / negative phase strobes
//   pe3M5 / ne3M5 : 3.5 MHz positive / negative phase strobes
//   ceCpu         : CPU clock enable at the selected turbo rate
//   rst_n         : registered active-low system reset
// master = clock_enable (driver), slave = downstream consumers.
interface clock_enable_if;

    logic pe7M;
    logic ne7M;
    logic pe3M5;
    logic ne3M5;
    logic ceCpu;
    logic rst_n;

    modport master (
        output pe7M, ne7M, pe3M5, ne3M5, ceCpu, rst_n
    );

    modport slave (
        input pe7M, ne7M, pe3M5, ne3M5, ceCpu, rst_n
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser with an active-low synchronous clear.
//   i_clk   : destination clock
//   i_clr_n : synchronous clear, active low (both stages cleared to 0)
//   i_d     : asynchronous input
//   o_q     : synchronised output, two i_clk edges after i_d changes
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_enable.sv
// Clock-enable and system-reset generator fed by the DCM 56 MHz output.
// A single 4-bit phase counter runs while the synchronised LOCKED flag is
// high; every strobe is a registered decode of that counter. The system
// reset is stretched after lock and after soft-reset requests.
//   clock  : 56 MHz system clock
//   reset  : synchronous active-low reset
//   locked : DCM LOCKED, asynchronous to clock
//   rq     : soft-reset request (level)
//   turbo  : CPU speed select, latched once per 16-cycle period
//   ce     : strobe/reset bundle (clock_enable_if.master)
module clock_enable
    import clock_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 1024
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           locked,
    input  logic           rq,
    input  logic [1:0]     turbo,
    clock_enable_if.master ce
);

    localparam logic [15:0] STRETCH_RELOAD = 16'(RESET_CYCLES - 1);

    logic       w_lk;
    logic [3:0] w_cnt_next;
    logic       w_reload;

    logic [3:0]  r_cnt;
    turbo_t      r_turbo_l;
    logic        r_pe7M;
    logic        r_ne7M;
    logic        r_pe3M5;
    logic        r_ne3M5;
    logic        r_ceCpu;
    logic [15:0] r_stretch;
    logic        r_expired;
    logic        r_rst_n;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (clock),
        .i_clr_n (reset),
        .i_d     (locked),
        .o_q     (w_lk)
    );

    always_comb begin
        w_cnt_next = w_lk ? r_cnt + 4'd1 : '0;
        w_reload   = !w_lk || rq;
    end

    // Strobes decode the next count so each one is high in exactly the
    // cycle r_cnt holds its phase. When r_cnt is CNT_LAST the next count
    // is 0, which no CPU mode decodes, so latching turbo on that same edge
    // never loses or duplicates a pulse across the period boundary.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_turbo_l <= TURBO_3M5;
            r_pe7M    <= 1'b0;
            r_ne7M    <= 1'b0;
            r_pe3M5   <= 1'b0;
            r_ne3M5   <= 1'b0;
            r_ceCpu   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (r_cnt == CNT_LAST) begin
                r_turbo_l <= turbo_t'(turbo);
            end
            r_pe7M  <= w_lk && (w_cnt_next[2:0] == PH_PE7M[2:0]);
            r_ne7M  <= w_lk && (w_cnt_next[2:0] == PH_NE7M[2:0]);
            r_pe3M5 <= w_lk && (w_cnt_next == PH_PE3M5);
            r_ne3M5 <= w_lk && (w_cnt_next == PH_NE3M5);
            r_ceCpu <= w_lk && ce_cpu_hit(r_turbo_l, w_cnt_next);
        end
    end

    // rst_n releases one cycle after the counter has sat at 0 for a cycle
    // (r_expired), giving RESET_CYCLES+1 cycles from the last reload.
    always_ff @(posedge clock) begin
        if (!reset || w_reload) begin
            r_stretch <= STRETCH_RELOAD;
            r_expired <= 1'b0;
            r_rst_n   <= 1'b0;
        end else begin
            if (r_stretch != '0) begin
                r_stretch <= r_stretch - 16'd1;
            end
            r_expired <= (r_stretch == '0);
            r_rst_n   <= r_expired;
        end
    end

    assign ce.pe7M  = r_pe7M;
    assign ce.ne7M  = r_ne7M;
    assign ce.pe3M5 = r_pe3M5;
    assign ce.ne3M5 = r_ne3M5;
    assign ce.ceCpu = r_ceCpu;
    assign ce.rst_n = r_rst_n;

endmodule
